// File: rtl/eth_tx_pkg.sv
// Shared types and Ethernet-derived defaults for the TX stream arbiter.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int ETH_IFG_BYTES = 12;
  localparam int ETH_MAX_FRAME = 1518;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int w_idx;
    w_idx    = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (i_req[IDX_W'(w_idx)]) begin
        o_winner = IDX_W'(w_idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter onto the RMII MAC TX stream, with
// inter-frame gap enforcement and truncation of oversize frames.
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin
// PASS  | granted source forwarded to MAC until tlast or size limit
// DRAIN | truncated frame: remainder consumed and dropped up to its tlast
// GAP   | IFG_CYCLES idle cycles before the next arbitration
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = 8,
  parameter int IFG_CYCLES = ETH_IFG_BYTES,
  parameter int MAX_FRAME  = ETH_MAX_FRAME
) (
  input  logic                        clk_0,
  input  logic                        reset_n_0,
  input  logic [NUM_REQ*DATA_W-1:0]   s_tdata,
  input  logic [NUM_REQ-1:0]          s_tvalid,
  input  logic [NUM_REQ-1:0]          s_tlast,
  output logic [NUM_REQ-1:0]          s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        oversize
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_FRAME + 1);
  localparam int GAP_W  = $clog2(IFG_CYCLES + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_FRAME - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(IFG_CYCLES);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_winner;
  logic               w_any;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_busy;
  logic               r_oversize;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_at_limit;
  logic               w_pass_hs;
  logic               w_drain_hs;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req    (s_tvalid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_sel_data  = s_tdata[int'(r_grant)*DATA_W +: DATA_W];
  assign w_sel_valid = s_tvalid[r_grant];
  assign w_sel_last  = s_tlast[r_grant];
  assign w_at_limit  = (r_beat_cnt == BEAT_LAST);
  assign w_pass_hs   = (r_state == PASS) && w_sel_valid && m_tready;
  assign w_drain_hs  = (r_state == DRAIN) && w_sel_valid;

  always_ff @(posedge clk_0 or negedge reset_n_0) begin
    if (!reset_n_0) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A forced-limit beat that also carries tlast is an ordinary frame end.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_any) w_state_nxt = PASS;
      PASS: begin
        if (w_pass_hs) begin
          if (w_sel_last)      w_state_nxt = GAP;
          else if (w_at_limit) w_state_nxt = DRAIN;
        end
      end
      DRAIN: if (w_drain_hs && w_sel_last) w_state_nxt = GAP;
      GAP:   if (r_gap_cnt == GAP_W'(1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or negedge reset_n_0) begin
    if (!reset_n_0) begin
      r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
      r_busy     <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != IDLE);
      r_oversize <= w_pass_hs && w_at_limit && !w_sel_last;
      if (r_state == IDLE && w_any) begin
        r_grant    <= w_winner;
        r_rr_ptr   <= w_winner;
        r_beat_cnt <= '0;
      end else if (w_pass_hs) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
      if (w_state_nxt == GAP && r_state != GAP) begin
        r_gap_cnt <= GAP_LOAD;
      end else if (r_state == GAP) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    unique case (r_state)
      PASS: begin
        m_tdata           = w_sel_data;
        m_tvalid          = w_sel_valid;
        m_tlast           = w_sel_last | w_at_limit;
        s_tready[r_grant] = m_tready;
      end
      DRAIN:   s_tready[r_grant] = 1'b1;
      default: ;
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign oversize = r_oversize;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench: one arbiter at default limits, one with MAX_FRAME=16,
// both driven from the same two frame-source models.
module tb_eth_tx_arbiter;

  logic        clk_0 = 1'b0;
  logic        reset_n_0;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tlast;
  logic        m_tready;

  logic [1:0]  s_tready_a, s_tready_b;
  logic [7:0]  m_tdata_a, m_tdata_b;
  logic        m_tvalid_a, m_tvalid_b;
  logic        m_tlast_a, m_tlast_b;
  logic        grant_id_a, grant_id_b;
  logic        busy_a, busy_b;
  logic        oversize_a, oversize_b;

  always #5 clk_0 = ~clk_0;

  eth_tx_arbiter dut_a (
    .clk_0(clk_0), .reset_n_0(reset_n_0),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_a),
    .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tlast(m_tlast_a), .m_tready(m_tready),
    .grant_id(grant_id_a), .busy(busy_a), .oversize(oversize_a)
  );

  eth_tx_arbiter #(.MAX_FRAME(16)) dut_b (
    .clk_0(clk_0), .reset_n_0(reset_n_0),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_b),
    .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tlast(m_tlast_b), .m_tready(m_tready),
    .grant_id(grant_id_b), .busy(busy_b), .oversize(oversize_b)
  );

  int checks = 0;
  int errors = 0;

  bit         sel_b;
  bit         rand_rdy;
  int         frames_left[2];
  int         flen[2];
  int         beat[2];
  logic [7:0] base[2];

  int         cyc, last_end, busy_cnt, ovs_cnt, drain_cnt, rdy1_cnt, mirror_bad;
  bit         in_frame;
  logic [7:0] out_q[$];
  bit         last_q[$];
  int         grant_q[$];
  int         gap_q[$];

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i]       = (frames_left[i] > 0);
      s_tdata[i*8 +: 8] = base[i] + 8'(beat[i]);
      s_tlast[i]        = (frames_left[i] > 0) && (beat[i] == flen[i] - 1);
    end
  endtask

  // One clock: observe the selected DUT at negedge, advance sources after posedge.
  task automatic step();
    logic [1:0] rdy;
    logic       mv, ml, bz, ov, g;
    logic [7:0] md;
    bit         adv[2];
    @(negedge clk_0);
    rdy = sel_b ? s_tready_b : s_tready_a;
    mv  = sel_b ? m_tvalid_b : m_tvalid_a;
    ml  = sel_b ? m_tlast_b  : m_tlast_a;
    md  = sel_b ? m_tdata_b  : m_tdata_a;
    bz  = sel_b ? busy_b     : busy_a;
    ov  = sel_b ? oversize_b : oversize_a;
    g   = sel_b ? grant_id_b : grant_id_a;
    cyc++;
    if (bz) busy_cnt++;
    if (ov) ovs_cnt++;
    if (rdy[1]) rdy1_cnt++;
    if (rdy[1] !== (mv ? m_tready : 1'b0)) mirror_bad++;
    if (mv && m_tready) begin
      if (!in_frame) begin
        grant_q.push_back(int'(g));
        if (last_end >= 0) gap_q.push_back(cyc - last_end - 1);
        in_frame = 1;
      end
      out_q.push_back(md);
      last_q.push_back(ml);
      if (ml) begin
        in_frame = 0;
        last_end = cyc;
      end
    end
    for (int i = 0; i < 2; i++) begin
      adv[i] = s_tvalid[i] && rdy[i];
      if (adv[i] && !mv) drain_cnt++;
    end
    @(posedge clk_0);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (adv[i]) begin
        beat[i]++;
        if (beat[i] == flen[i]) begin
          beat[i] = 0;
          frames_left[i]--;
        end
      end
    end
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    drive();
  endtask

  task automatic apply_reset();
    reset_n_0   = 1'b0;
    frames_left = '{0, 0};
    beat        = '{0, 0};
    flen        = '{1, 1};
    base        = '{8'h00, 8'h00};
    m_tready    = 1'b1;
    rand_rdy    = 0;
    drive();
    out_q.delete();
    last_q.delete();
    grant_q.delete();
    gap_q.delete();
    cyc = 0; last_end = -1; busy_cnt = 0; ovs_cnt = 0; drain_cnt = 0;
    rdy1_cnt = 0; mirror_bad = 0; in_frame = 0;
    repeat (2) @(posedge clk_0);
    #1 reset_n_0 = 1'b1;
  endtask

  task automatic run_idle(input int maxc, output bit ok);
    int n;
    n  = 0;
    ok = 0;
    step();
    while (n < maxc) begin
      step();
      n++;
      if (frames_left[0] == 0 && frames_left[1] == 0 && !(sel_b ? busy_b : busy_a)) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n_0 = 1'b1;
    m_tready  = 1'b1;
    frames_left = '{0, 0}; beat = '{0, 0}; flen = '{1, 1}; base = '{8'h00, 8'h00};
    drive();
    #2 reset_n_0 = 1'b0;
    #2;
    checks++;
    if ({m_tvalid_a, m_tlast_a, m_tdata_a, s_tready_a, grant_id_a, busy_a, oversize_a} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want all zero",
               {m_tvalid_a, m_tlast_a, m_tdata_a, s_tready_a, grant_id_a, busy_a, oversize_a});
    end
    apply_reset();
    repeat (3) step();
    checks++;
    if (busy_cnt !== 0 || m_tvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got busy_cycles=%0d m_tvalid=%b want 0 0", busy_cnt, m_tvalid_a);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int bad;
    apply_reset();
    sel_b = 0;
    flen[0] = 64; frames_left[0] = 1;
    drive();
    run_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got busy want idle"); end
    checks++;
    if (out_q.size() !== 64) begin
      errors++; $display("FAIL single_len got %0d want 64", out_q.size());
    end
    bad = 0;
    foreach (out_q[i]) if (out_q[i] !== 8'(i) || last_q[i] !== (i == 63)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL single_data got %0d bad beats want 0", bad); end
    checks++;
    if (busy_cnt !== 76) begin errors++; $display("FAIL single_busy got %0d want 76", busy_cnt); end
    checks++;
    if (rdy1_cnt !== 0) begin errors++; $display("FAIL single_rdy1 got %0d want 0", rdy1_cnt); end
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    sel_b = 0;
    flen = '{10, 10}; frames_left = '{4, 4}; base = '{8'h00, 8'h80};
    drive();
    run_idle(800, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_timeout got busy want idle"); end
    checks++;
    if (grant_q.size() !== 8) begin
      errors++; $display("FAIL cont_frames got %0d want 8", grant_q.size());
    end
    foreach (grant_q[i]) begin
      checks++;
      if (grant_q[i] !== i % 2) begin
        errors++; $display("FAIL cont_grant[%0d] got %0d want %0d", i, grant_q[i], i % 2);
      end
    end
    checks++;
    if (gap_q.size() !== 7) begin errors++; $display("FAIL cont_gaps got %0d want 7", gap_q.size()); end
    foreach (gap_q[i]) begin
      checks++;
      if (gap_q[i] < 12) begin
        errors++; $display("FAIL cont_ifg[%0d] got %0d want >=12", i, gap_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    apply_reset();
    sel_b = 0;
    rand_rdy = 1;
    flen[1] = 100; frames_left[1] = 1;
    drive();
    run_idle(2000, ok);
    rand_rdy = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got busy want idle"); end
    checks++;
    if (out_q.size() !== 100) begin errors++; $display("FAIL bp_len got %0d want 100", out_q.size()); end
    bad = 0;
    foreach (out_q[i]) if (out_q[i] !== 8'(i) || last_q[i] !== (i == 99)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_data got %0d bad beats want 0", bad); end
    checks++;
    if (mirror_bad !== 0) begin errors++; $display("FAIL bp_mirror got %0d bad cycles want 0", mirror_bad); end
  endtask

  task automatic test_oversize();
    bit ok;
    int bad;
    apply_reset();
    sel_b = 1;
    flen = '{20, 8}; frames_left = '{1, 1}; base = '{8'h00, 8'h40};
    drive();
    run_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovs_timeout got busy want idle"); end
    checks++;
    if (out_q.size() !== 24) begin errors++; $display("FAIL ovs_len got %0d want 24", out_q.size()); end
    bad = 0;
    foreach (out_q[i]) begin
      if (i < 16) begin
        if (out_q[i] !== 8'(i) || last_q[i] !== (i == 15)) bad++;
      end else begin
        if (out_q[i] !== 8'h40 + 8'(i - 16) || last_q[i] !== (i == 23)) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ovs_data got %0d bad beats want 0", bad); end
    checks++;
    if (ovs_cnt !== 1) begin errors++; $display("FAIL ovs_pulse got %0d want 1", ovs_cnt); end
    checks++;
    if (drain_cnt !== 4) begin errors++; $display("FAIL ovs_drain got %0d want 4", drain_cnt); end
    checks++;
    if (grant_q.size() !== 2 || grant_q[0] !== 0 || grant_q[1] !== 1) begin
      errors++; $display("FAIL ovs_grants got %0d frames want 2 (0 then 1)", grant_q.size());
    end
  endtask

  task automatic test_exact_limit();
    bit ok;
    int nlast;
    apply_reset();
    sel_b = 1;
    flen[0] = 16; frames_left[0] = 1;
    drive();
    run_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL exact_timeout got busy want idle"); end
    nlast = 0;
    foreach (last_q[i]) if (last_q[i]) nlast++;
    checks++;
    if (out_q.size() !== 16 || nlast !== 1 || last_q[15] !== 1'b1) begin
      errors++; $display("FAIL exact_frame got len=%0d lasts=%0d want 16 1", out_q.size(), nlast);
    end
    checks++;
    if (ovs_cnt !== 0 || drain_cnt !== 0) begin
      errors++; $display("FAIL exact_nodrain got ovs=%0d drain=%0d want 0 0", ovs_cnt, drain_cnt);
    end
    checks++;
    if (busy_cnt !== 28) begin errors++; $display("FAIL exact_busy got %0d want 28", busy_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    apply_reset();
    sel_b = 0;
    flen[0] = 30; frames_left[0] = 1;
    drive();
    n = 0;
    while (out_q.size() < 5 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (out_q.size() !== 5) begin errors++; $display("FAIL mid_reach got %0d beats want 5", out_q.size()); end
    #2 reset_n_0 = 1'b0;
    #1;
    checks++;
    if ({m_tvalid_a, m_tlast_a, m_tdata_a, s_tready_a, grant_id_a, busy_a, oversize_a} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b want all zero",
               {m_tvalid_a, m_tlast_a, m_tdata_a, s_tready_a, grant_id_a, busy_a, oversize_a});
    end
    apply_reset();
    flen = '{4, 4}; frames_left = '{1, 1};
    drive();
    run_idle(200, ok);
    checks++;
    if (!ok || grant_q.size() < 1 || grant_q[0] !== 0) begin
      errors++; $display("FAIL mid_first_grant got frames=%0d ok=%0d want source 0 first", grant_q.size(), ok);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_b    = 0;
    rand_rdy = 0;
    test_reset();
    test_single_frame();
    test_contention();
    test_backpressure();
    test_oversize();
    test_exact_limit();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
